iir_deemph: RTL and testbench

Recursive first-order de-emphasis filter: y[n] = x[n] + y[n-1]/(1+TIMECONSTANT). It exactly inverts the team's first-order pre-emphasis filter, which computes y[n] = x[n] − x[n-1]/(1+TIMECONSTANT) in 16-bit wrapping arithmetic with truncating division. The block sits on the receive side of the sample path. Samples arrive and leave over valid/ready handshakes. The division is done by an iterative shift-subtract divider, so there is no combinational divider.

---
 rtl/iir_deemph_if.sv | 22 ++
 rtl/iir_deemph.sv | 148 ++++++++++++++
 tb/tb_iir_deemph.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/iir_deemph_if.sv
// Sample-path handshake bundle for iir_deemph: input valid/ready channel
// and output valid/ready channel.
interface iir_deemph_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] data_i;
  logic                     valid_i;
  logic                     ready_o;
  logic signed [DATA_W-1:0] data_o;
  logic                     valid_o;
  logic                     ready_i;

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );
endinterface

// File: rtl/iir_deemph.sv
// First-order de-emphasis IIR: y[n] = x[n] + y[n-1]/(1+TIMECONSTANT), iterative divider.
// Optional macro IIR_DEEMPH_SAT_EN clamps the output sum instead of wrapping.
module iir_deemph #(
  parameter int TIMECONSTANT = 9,
  parameter int DATA_W       = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  iir_deemph_if.slave bus
);

  localparam int                CNT_W   = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] DIVISOR = DATA_W'(TIMECONSTANT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_ADD,
    S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic signed [DATA_W-1:0] y_prev_q, y_prev_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        dvd_q, dvd_d;
  logic [DATA_W:0]          rem_q, rem_d;

  logic                     accept;
  logic [DATA_W:0]          rem_shift;
  logic                     take;
  logic signed [DATA_W-1:0] quot_s;
  logic signed [DATA_W-1:0] sum;

  // Magnitude as unsigned; the most negative value maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] u;
    u = v;
    return v[DATA_W-1] ? (~u + 1'b1) : u;
  endfunction

  // Truncation toward zero: quotient magnitude takes the dividend's sign.
  function automatic logic signed [DATA_W-1:0] apply_sign(
    input logic [DATA_W-1:0] mag,
    input logic              neg
  );
    return neg ? $signed(~mag + 1'b1) : $signed(mag);
  endfunction

`ifdef IIR_DEEMPH_SAT_EN
  function automatic logic signed [DATA_W-1:0] sat_sum(input logic signed [DATA_W:0] s);
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return s[DATA_W-1:0];
  endfunction
`endif

  assign accept = (state_q == S_IDLE) && bus.valid_i;

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.valid_i)       state_d = S_DIV;
      S_DIV:  if (cnt_q == CNT_LAST) state_d = S_ADD;
      S_ADD:                         state_d = S_OUT;
      S_OUT:  if (bus.ready_i)       state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from registered state only
  always_comb begin
    bus.ready_o = (state_q == S_IDLE);
    bus.valid_o = (state_q == S_OUT);
  end

  // Restoring shift-subtract step: dividend bits shift out the top, quotient bits shift in below.
  always_comb begin
    rem_shift = {rem_q[DATA_W-1:0], dvd_q[DATA_W-1]};
    take      = (rem_shift >= {1'b0, DIVISOR});
    quot_s    = apply_sign(dvd_q, y_prev_q[DATA_W-1]);
`ifdef IIR_DEEMPH_SAT_EN
    sum = sat_sum({x_q[DATA_W-1], x_q} + {quot_s[DATA_W-1], quot_s});
`else
    sum = x_q + quot_s;
`endif
  end

  always_comb begin
    x_d      = x_q;
    y_prev_d = y_prev_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d   = bus.data_i;
          cnt_d = '0;
          dvd_d = abs_mag(y_prev_q);
          rem_d = '0;
        end
      end
      S_DIV: begin
        rem_d = take ? (rem_shift - {1'b0, DIVISOR}) : rem_shift;
        dvd_d = {dvd_q[DATA_W-2:0], take};
        cnt_d = cnt_q + 1'b1;
      end
      S_ADD: begin
        data_d   = sum;
        y_prev_d = sum;
      end
      default: ;
    endcase
  end

  // Datapath registers; all cleared so an interrupted sample leaves no trace
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_q      <= '0;
      y_prev_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
    end else begin
      x_q      <= x_d;
      y_prev_q <= y_prev_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
    end
  end

  assign bus.data_o = data_q;

endmodule

// File: tb/tb_iir_deemph.sv
// Directed bench for iir_deemph with TIMECONSTANT=9 (divisor 10); hand-computed expectations.
module tb_iir_deemph;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  iir_deemph_if #(.DATA_W(16)) bus ();

  iir_deemph #(.TIMECONSTANT(9), .DATA_W(16)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic accept(input int x);
    int cyc;
    cyc = 0;
    while (!bus.ready_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 100) chk("ready_timeout", 0, 1);
    bus.data_i  = 16'(x);
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.valid_o && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic send_expect(input string tag, input int x, input int exp);
    int cyc;
    accept(x);
    wait_valid(cyc);
    chk({tag, "_lat"}, cyc, 17);
    chk(tag, bus.data_o, exp);
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
  endtask

  initial begin
    int cyc;
    int seen;
    bus.data_i  = '0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_data", bus.data_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    send_expect("imp_p0", 1000, 1000);
    send_expect("imp_p1", 0, 100);
    send_expect("imp_p2", 0, 10);
    send_expect("imp_p3", 0, 1);
    send_expect("imp_p4", 0, 0);
    send_expect("imp_n0", -1000, -1000);
    send_expect("imp_n1", 0, -100);
    send_expect("imp_n2", 0, -10);
    send_expect("imp_n3", 0, -1);
    send_expect("imp_n4", 0, 0);

    send_expect("rt0", 100, 100);
    send_expect("rt1", 190, 200);
    send_expect("rt2", -320, -300);

    // Backpressure: y_prev=-300, input 0 -> -30, held for 5 cycles
    accept(0);
    wait_valid(cyc);
    chk("bp_lat", cyc, 17);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.data_i  = 16'sd7;
        bus.valid_i = 1'b1;
      end
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      chk("bp_valid", bus.valid_o, 1);
      chk("bp_data", bus.data_o, -30);
      chk("bp_ready", bus.ready_o, 0);
    end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    bus.ready_i = 1'b0;
    chk("bp_release_ready", bus.ready_o, 1);
    chk("bp_release_valid", bus.valid_o, 0);
    send_expect("bp_after", 0, -3);

    // Asynchronous reset while an output is pending
    accept(1000);
    wait_valid(cyc);
    chk("pre_rst_data", bus.data_o, 1000);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", bus.valid_o, 0);
    chk("arst_data", bus.data_o, 0);
    chk("arst_ready", bus.ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_expect("post_rst", 500, 500);

    // Reset in the middle of the division
    accept(1234);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("middiv_ready", bus.ready_o, 1);
    chk("middiv_valid", bus.valid_o, 0);
    chk("middiv_data", bus.data_o, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.valid_o) seen++;
    end
    chk("middiv_novalid", seen, 0);
    send_expect("middiv_next", 50, 50);

    // Overflow on a clean filter state
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_expect("ovf0", 32767, 32767);
`ifdef IIR_DEEMPH_SAT_EN
    send_expect("ovf1", 32767, 32767);
`else
    send_expect("ovf1", 32767, -29493);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
